gpio_seq: RTL and testbench

- Sits between the CPU peripheral bus and the gpio register port.
- Passes CPU accesses through to the gpio block unchanged.
- Adds a timed pattern sequencer that writes queued values into GPIO_DATA (offset 0x4) at a programmable interval, so the core does not have to bit-bang the pins.
- Arbitrates the single gpio write port between the CPU and the sequencer. The CPU always wins.

---
 rtl/gpio_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_gpio_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_seq
//  Description : CPU-to-gpio passthrough with a timed pattern sequencer.
//                addr_i[4]=0 forwards the access to the gpio register port.
//                addr_i[4]=1 selects the local registers:
//                  0x10 CTRL, 0x14 DIV, 0x18 PAT, 0x1C STATUS.
//                While running, the sequencer writes queued patterns to
//                GPIO_DATA (0x4) every DIV+1 cycles. A CPU gpio write always
//                wins the shared port, and a blocked sequencer write is
//                retried on the following cycles.
//  Ports       : clk, rst (sync, active-low)
//                we_i/addr_i/data_i/data_o        : CPU side
//                gpio_we_o/gpio_addr_o/gpio_data_o
//                gpio_rdata_i                     : gpio register port
//                busy_o                           : sequencer in RUN/PEND
//                irq_o (GPIO_SEQ_IRQ_EN only)     : DONE & IRQ_EN level
//  Options     : `define GPIO_SEQ_IRQ_EN adds irq_o, CTRL.IRQ_EN (bit3) and
//                W1C of STATUS.DONE (bit8).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        gpio_we_o,
    output logic [31:0] gpio_addr_o,
    output logic [31:0] gpio_data_o,
    input  logic [31:0] gpio_rdata_i,
`ifdef GPIO_SEQ_IRQ_EN
    output logic        irq_o,
`endif
    output logic        busy_o
);

    localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_IDX_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_en;
    logic           r_loop;
    logic           r_irq_en;
    logic [31:0]    r_div;
    logic [31:0]    r_cnt;
    logic [AW-1:0]  r_rd_idx;
    logic [AW:0]    r_count;
    logic           r_done;
    logic           r_ovf;
    logic [31:0]    r_buf [DEPTH];

    logic           w_cpu_gwr;
    logic           w_wr_ctrl;
    logic           w_wr_div;
    logic           w_wr_pat;
    logic           w_wr_stat;
    logic           w_flush;
    logic           w_busy;
    logic           w_idle;
    logic           w_abort;
    logic           w_start;
    logic           w_empty_en;
    logic           w_full;
    logic           w_last;
    logic           w_fire;
    logic [31:0]    w_ctrl_rd;
    logic [31:0]    w_status;
    logic [31:0]    w_reg_rdata;
    logic           w_unused_addr;

    assign w_unused_addr = ^addr_i[31:5];

    // ---------------- decode ----------------
    assign w_cpu_gwr  = we_i & ~addr_i[4];
    assign w_wr_ctrl  = we_i & addr_i[4] & (addr_i[3:0] == 4'h0);
    assign w_wr_div   = we_i & addr_i[4] & (addr_i[3:0] == 4'h4);
    assign w_wr_pat   = we_i & addr_i[4] & (addr_i[3:0] == 4'h8);
    assign w_wr_stat  = we_i & addr_i[4] & (addr_i[3:0] == 4'hC);

    assign w_flush    = w_wr_ctrl & data_i[2];
    assign w_busy     = (r_state == S_RUN) || (r_state == S_PEND);
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_abort    = w_wr_ctrl & ~data_i[0] & w_busy;
    assign w_start    = w_wr_ctrl & data_i[0] & ~data_i[2] & w_idle & (r_count != '0);
    assign w_empty_en = w_wr_ctrl & data_i[0] & ~data_i[2] & w_idle & (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_last     = ({1'b0, r_rd_idx} == (r_count - c_CNT_ONE));

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = w_start ? S_RUN : S_IDLE;
            end
            S_RUN, S_PEND: begin
                // PEND always retries; RUN fires only when the interval expires.
                if ((r_state == S_PEND) || (r_cnt == '0)) begin
                    if (w_cpu_gwr) begin
                        w_state_nxt = S_PEND;
                    end else begin
                        w_fire      = 1'b1;
                        w_state_nxt = (w_last && !r_loop) ? S_DONE : S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort/flush take effect in the writing cycle and discard any fire;
        // a fire is also suppressed while reset is held.
        if (w_flush || w_abort || !rst) begin
            w_state_nxt = S_IDLE;
            w_fire      = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en     <= 1'b0;
            r_loop   <= 1'b0;
            r_irq_en <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= data_i[0];
                r_loop <= data_i[1];
`ifdef GPIO_SEQ_IRQ_EN
                r_irq_en <= data_i[3];
`endif
            end
            if (w_wr_div) begin
                r_div <= data_i;
            end

            if (w_start) begin
                r_cnt    <= '0;
                r_rd_idx <= '0;
            end else if (w_fire) begin
                // Reload from the actual write so retried fires keep spacing.
                r_cnt    <= r_div;
                r_rd_idx <= w_last ? '0 : r_rd_idx + c_IDX_ONE;
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 32'd1;
            end

            if (w_flush) begin
                r_count  <= '0;
                r_rd_idx <= '0;
                r_ovf    <= 1'b0;
            end else if (w_wr_pat) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end

            if (w_empty_en || (w_fire && w_last && !r_loop)) begin
                r_done <= 1'b1;
            end else if (w_start) begin
                r_done <= 1'b0;
`ifdef GPIO_SEQ_IRQ_EN
            end else if (w_wr_stat && data_i[8]) begin
                r_done <= 1'b0;
`endif
            end
        end
    end

    // Pattern storage is deliberately left unreset. Entries are never
    // consumed, so the write slot is simply the current count.
    always_ff @(posedge clk) begin
        if (w_wr_pat && !w_full) begin
            r_buf[r_count[AW-1:0]] <= data_i;
        end
    end

    // ---------------- readback ----------------
    always_comb begin
        w_ctrl_rd    = '0;
        w_ctrl_rd[0] = r_en;
        w_ctrl_rd[1] = r_loop;
`ifdef GPIO_SEQ_IRQ_EN
        w_ctrl_rd[3] = r_irq_en;
`endif
        w_status       = '0;
        w_status[AW:0] = r_count;
        w_status[8]    = r_done;
        w_status[9]    = r_ovf;
        w_status[10]   = w_busy;
        case (addr_i[3:0])
            4'h0:    w_reg_rdata = w_ctrl_rd;
            4'h4:    w_reg_rdata = r_div;
            4'hC:    w_reg_rdata = w_status;
            default: w_reg_rdata = '0;
        endcase
    end

    // ---------------- outputs ----------------
    assign gpio_we_o   = w_fire | w_cpu_gwr;
    assign gpio_addr_o = w_fire ? 32'h4 : {28'h0, addr_i[3:0]};
    assign gpio_data_o = w_fire ? r_buf[r_rd_idx] : data_i;
    assign data_o      = !rst ? 32'h0 : (addr_i[4] ? w_reg_rdata : gpio_rdata_i);
    assign busy_o      = w_busy;
`ifdef GPIO_SEQ_IRQ_EN
    assign irq_o       = r_done & r_irq_en;
`else
    logic w_unused_irq;
    assign w_unused_irq = r_irq_en ^ w_wr_stat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_seq
//  Description : Directed self-checking bench for gpio_seq (DEPTH=8).
//                Inputs change 1ns after the rising edge; outputs are
//                sampled on the falling edge of the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_seq;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        gpio_we_o;
    logic [31:0] gpio_addr_o;
    logic [31:0] gpio_data_o;
    logic [31:0] gpio_rdata_i;
    logic        busy_o;
`ifdef GPIO_SEQ_IRQ_EN
    logic        irq_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    gpio_seq #(.DEPTH(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .gpio_we_o    (gpio_we_o),
        .gpio_addr_o  (gpio_addr_o),
        .gpio_data_o  (gpio_data_o),
        .gpio_rdata_i (gpio_rdata_i),
`ifdef GPIO_SEQ_IRQ_EN
        .irq_o        (irq_o),
`endif
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupy one bus cycle with the given access.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we_i   = we;
        addr_i = a;
        data_i = d;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        gpio_rdata_i = 32'hDEAD_BEEF;
        drive(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL reset_data_o got %h want 00000000", data_o);
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_busy got %b want 0", busy_o);
        end
        @(posedge clk); #1;
        rst = 1'b1; addr_i = 32'h1C; gpio_rdata_i = 32'h0;
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL reset_status got %h want 00000000", data_o);
        end
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL reset_ctrl got %h want 00000000", data_o);
        end
        drive(1'b0, 32'h14, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL reset_div got %h want 00000000", data_o);
        end
    endtask

    task automatic test_passthrough;
        drive(1'b1, 32'h0, 32'h10);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== 32'h0 || gpio_data_o !== 32'h10) begin
            n_err++;
            $display("FAIL pass_write got we=%b a=%h d=%h want we=1 a=00000000 d=00000010",
                     gpio_we_o, gpio_addr_o, gpio_data_o);
        end
        drive(1'b0, 32'h0, 32'h0);
        gpio_rdata_i = 32'h10;
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h10 || gpio_we_o !== 1'b0) begin
            n_err++; $display("FAIL pass_read got d=%h we=%b want 00000010 we=0", data_o, gpio_we_o);
        end
        drive(1'b1, 32'hFFFF_FFEC, 32'h1234_5678);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== 32'hC || gpio_data_o !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL pass_addr got we=%b a=%h d=%h want we=1 a=0000000c d=12345678",
                     gpio_we_o, gpio_addr_o, gpio_data_o);
        end
        drive(1'b1, 32'h14, 32'h0);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b0) begin
            n_err++; $display("FAIL pass_regwin_we got %b want 0", gpio_we_o);
        end
        gpio_rdata_i = 32'h0;
    endtask

    task automatic test_basic;
        logic        exp_we;
        logic [31:0] exp_d;
        drive(1'b1, 32'h14, 32'd3);
        drive(1'b1, 32'h18, 32'h1);
        drive(1'b1, 32'h18, 32'h2);
        drive(1'b1, 32'h18, 32'h3);
        drive(1'b1, 32'h10, 32'h1);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b0) begin
            n_err++; $display("FAIL basic_enable_cycle got we=%b want 0", gpio_we_o);
        end
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 32'h1C, 32'h0);
            @(negedge clk);
            exp_we = (k == 1) || (k == 5) || (k == 9);
            exp_d  = (k == 1) ? 32'h1 : ((k == 5) ? 32'h2 : 32'h3);
            n_vec++;
            if (gpio_we_o !== exp_we) begin
                n_err++; $display("FAIL basic_we k=%0d got %b want %b", k, gpio_we_o, exp_we);
            end
            if (exp_we) begin
                n_vec++;
                if (gpio_addr_o !== 32'h4 || gpio_data_o !== exp_d) begin
                    n_err++;
                    $display("FAIL basic_fire k=%0d got a=%h d=%h want a=00000004 d=%h",
                             k, gpio_addr_o, gpio_data_o, exp_d);
                end
            end
            n_vec++;
            if (busy_o !== (k <= 9)) begin
                n_err++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy_o, (k <= 9));
            end
            if (k == 1 || k == 10) begin
                n_vec++;
                if (data_o !== ((k == 1) ? 32'h403 : 32'h103)) begin
                    n_err++;
                    $display("FAIL basic_status k=%0d got %h want %h", k, data_o,
                             ((k == 1) ? 32'h403 : 32'h103));
                end
            end
        end
    endtask

    task automatic test_collision;
        drive(1'b1, 32'h10, 32'h4);
        drive(1'b1, 32'h14, 32'h0);
        drive(1'b1, 32'h18, 32'hA1);
        drive(1'b1, 32'h18, 32'hA2);
        drive(1'b1, 32'h10, 32'h1);
        drive(1'b0, 32'h1C, 32'h0);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== 32'h4 || gpio_data_o !== 32'hA1) begin
            n_err++; $display("FAIL coll_first got we=%b a=%h d=%h want 1/4/a1",
                              gpio_we_o, gpio_addr_o, gpio_data_o);
        end
        drive(1'b1, 32'h0, 32'h55);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== 32'h0 || gpio_data_o !== 32'h55) begin
            n_err++; $display("FAIL coll_cpu got we=%b a=%h d=%h want 1/0/55",
                              gpio_we_o, gpio_addr_o, gpio_data_o);
        end
        drive(1'b0, 32'h1C, 32'h0);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b1 || gpio_addr_o !== 32'h4 || gpio_data_o !== 32'hA2) begin
            n_err++; $display("FAIL coll_retry got we=%b a=%h d=%h want 1/4/a2",
                              gpio_we_o, gpio_addr_o, gpio_data_o);
        end
        drive(1'b0, 32'h1C, 32'h0);
        @(negedge clk);
        n_vec++;
        if (gpio_we_o !== 1'b0 || data_o !== 32'h102) begin
            n_err++; $display("FAIL coll_done got we=%b status=%h want 0/00000102", gpio_we_o, data_o);
        end
    endtask

    task automatic test_loop_abort;
        logic        exp_we;
        logic [31:0] exp_d;
        drive(1'b1, 32'h10, 32'h4);
        drive(1'b1, 32'h14, 32'h1);
        drive(1'b1, 32'h10, 32'h2);
        drive(1'b1, 32'h18, 32'hAAAA);
        drive(1'b1, 32'h18, 32'hBBBB);
        drive(1'b1, 32'h10, 32'h3);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) drive(1'b1, 32'h10, 32'h2);
            else         drive(1'b0, 32'h1C, 32'h0);
            @(negedge clk);
            exp_we = (k % 2 == 1);
            exp_d  = (k % 4 == 1) ? 32'hAAAA : 32'hBBBB;
            n_vec++;
            if (gpio_we_o !== exp_we) begin
                n_err++; $display("FAIL loop_we k=%0d got %b want %b", k, gpio_we_o, exp_we);
            end
            if (exp_we) begin
                n_vec++;
                if (gpio_addr_o !== 32'h4 || gpio_data_o !== exp_d) begin
                    n_err++;
                    $display("FAIL loop_fire k=%0d got a=%h d=%h want a=00000004 d=%h",
                             k, gpio_addr_o, gpio_data_o, exp_d);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h1C, 32'h0);
            @(negedge clk);
            n_vec++;
            if (gpio_we_o !== 1'b0 || busy_o !== 1'b0) begin
                n_err++; $display("FAIL abort_quiet k=%0d got we=%b busy=%b want 0/0", k, gpio_we_o, busy_o);
            end
        end
        n_vec++;
        if (data_o !== 32'h002) begin
            n_err++; $display("FAIL abort_status got %h want 00000002", data_o);
        end
    endtask

    task automatic test_overflow_flush;
        drive(1'b1, 32'h10, 32'h4);
        for (int i = 0; i < 9; i++) drive(1'b1, 32'h18, 32'h100 + i);
        drive(1'b0, 32'h1C, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h208) begin
            n_err++; $display("FAIL ovf_status got %h want 00000208", data_o);
        end
        drive(1'b1, 32'h10, 32'h4);
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL flush_ctrl_read got %h want 00000000", data_o);
        end
        drive(1'b0, 32'h1C, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL flush_status got %h want 00000000", data_o);
        end
        drive(1'b1, 32'h10, 32'h1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h1C, 32'h0);
            @(negedge clk);
            n_vec++;
            if (gpio_we_o !== 1'b0 || busy_o !== 1'b0) begin
                n_err++; $display("FAIL empty_en_quiet k=%0d got we=%b busy=%b want 0/0", k, gpio_we_o, busy_o);
            end
        end
        n_vec++;
        if (data_o !== 32'h100) begin
            n_err++; $display("FAIL empty_en_status got %h want 00000100", data_o);
        end
    endtask

    task automatic test_reset_midrun;
        drive(1'b1, 32'h10, 32'h4);
        drive(1'b1, 32'h14, 32'd5);
        drive(1'b1, 32'h18, 32'h77);
        drive(1'b1, 32'h10, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 32'h1C, 32'h0);
            @(negedge clk);
            n_vec++;
            if (gpio_we_o !== (k == 1) || busy_o !== 1'b1) begin
                n_err++; $display("FAIL midrun_pre k=%0d got we=%b busy=%b want %b/1",
                                  k, gpio_we_o, busy_o, (k == 1));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; we_i = 1'b0; addr_i = 32'h1C;
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL midrun_in_reset_data got %h want 00000000", data_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || data_o !== 32'h0 || gpio_we_o !== 1'b0) begin
            n_err++; $display("FAIL midrun_after got busy=%b status=%h we=%b want 0/00000000/0",
                              busy_o, data_o, gpio_we_o);
        end
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_vec++;
        if (data_o !== 32'h0) begin
            n_err++; $display("FAIL midrun_ctrl got %h want 00000000", data_o);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'h14, 32'h0);
            @(negedge clk);
            n_vec++;
            if (gpio_we_o !== 1'b0 || data_o !== 32'h0) begin
                n_err++; $display("FAIL midrun_quiet k=%0d got we=%b div=%h want 0/00000000",
                                  k, gpio_we_o, data_o);
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        we_i         = 1'b0;
        addr_i       = 32'h0;
        data_i       = 32'h0;
        gpio_rdata_i = 32'h0;
        test_reset();
        test_passthrough();
        test_basic();
        test_collision();
        test_loop_abort();
        test_overflow_flush();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
